// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache types; this slice carries the LR/SC reservation state encoding.
package bp_be_dcache_pkg;

  typedef enum logic [1:0] {
    e_lrsc_idle,
    e_lrsc_locked,
    e_lrsc_reserved
  } bp_be_lrsc_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; saturation is left to the caller's enable.
module bsg_counter_clear_up #(
  parameter int max_val_p  = 127,
  parameter int init_val_p = 0,
  parameter int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  logic [ptr_width_lp-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      count_r <= ptr_width_lp'(init_val_p);
    else if (clear_i)
      count_r <= ptr_width_lp'(up_i);
    else if (up_i)
      count_r <= count_r + ptr_width_lp'(1);
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_be_dcache_lrsc_ctrl.sv
// Single-hart LR/SC reservation: holds the reserved block, withholds matching
// invalidates for a short lock window, and produces the SC verdict.
module bp_be_dcache_lrsc_ctrl
  import bp_be_dcache_pkg::*;
#(
  parameter int paddr_width_p        = 40,
  parameter int block_offset_width_p = 6,
  parameter int lock_cycles_p        = 16,
  parameter int timeout_cycles_p     = 128
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     lr_v_i,
  input  logic                     sc_v_i,
  input  logic                     double_i,
  input  logic [paddr_width_p-1:0] paddr_i,
  output logic                     sc_success_o,
  input  logic                     inv_v_i,
  input  logic [paddr_width_p-1:0] inv_addr_i,
  output logic                     inv_yumi_o,
  input  logic                     clear_i,
  output logic                     reserved_o,
  output logic                     locked_o
);

  localparam int block_width_lp = paddr_width_p - block_offset_width_p;
  localparam int cnt_width_lp   = $clog2(timeout_cycles_p);

  bp_be_lrsc_state_e state_r, state_n;
  logic [block_width_lp-1:0] block_r;
  logic                      double_r;
  logic [cnt_width_lp-1:0]   count;
  logic count_max, lock_done, sc_hit, inv_match, locked, reserved, inv_kill;

  bsg_counter_clear_up #(
    .max_val_p (timeout_cycles_p - 1),
    .init_val_p(timeout_cycles_p - 1)
  ) age_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(lr_v_i),
    .up_i   (~lr_v_i & ~count_max),
    .count_o(count)
  );

  assign count_max = (count == cnt_width_lp'(timeout_cycles_p - 1));
  assign lock_done = (count == cnt_width_lp'(lock_cycles_p - 1));

  assign inv_match = (inv_addr_i[paddr_width_p-1:block_offset_width_p] == block_r);
  assign sc_hit    = (paddr_i[paddr_width_p-1:block_offset_width_p] == block_r)
                   & (double_i == double_r);

  assign locked   = (state_r == e_lrsc_locked);
  assign reserved = locked | (state_r == e_lrsc_reserved);

  assign inv_yumi_o = inv_v_i & ~(locked & inv_match);
  // Only reachable in RESERVED, since a matching invalidate is stalled while LOCKED.
  assign inv_kill   = inv_yumi_o & inv_match & reserved;

  assign sc_success_o = sc_v_i & reserved & sc_hit & ~clear_i & ~lr_v_i & ~inv_kill;
  assign reserved_o   = reserved;
  assign locked_o     = locked;

  always_comb begin
    state_n = state_r;
    if (clear_i)
      state_n = e_lrsc_idle;
    else if (lr_v_i)
      state_n = e_lrsc_locked;
    else if (sc_v_i || inv_kill)
      state_n = e_lrsc_idle;
    else if (locked && lock_done)
      state_n = e_lrsc_reserved;
    else if (state_r == e_lrsc_reserved && count_max)
      state_n = e_lrsc_idle;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r  <= e_lrsc_idle;
      block_r  <= '0;
      double_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (lr_v_i && !clear_i) begin
        block_r  <= paddr_i[paddr_width_p-1:block_offset_width_p];
        double_r <= double_i;
      end
    end
  end

  logic unused;
  assign unused = ^{paddr_i[block_offset_width_p-1:0], inv_addr_i[block_offset_width_p-1:0]};

endmodule

// File: tb/tb_bp_be_dcache_lrsc_ctrl.sv
// Bench for the LR/SC reservation controller: vector table, directed corner
// sequences and random traffic, all scored against an age-based reference model.
module tb_bp_be_dcache_lrsc_ctrl;

  localparam int PW   = 40;
  localparam int BO   = 6;
  localparam int LOCK = 16;
  localparam int TMO  = 128;

  localparam logic [PW-1:0] A0    = 40'h00_8000_0000;
  localparam logic [PW-1:0] A40   = 40'h00_8000_0040;
  localparam logic [PW-1:0] A48   = 40'h00_8000_0048;
  localparam logic [PW-1:0] A78   = 40'h00_8000_0078;
  localparam logic [PW-1:0] A80   = 40'h00_8000_0080;
  localparam logic [PW-1:0] A100  = 40'h00_8000_0100;
  localparam logic [PW-1:0] A1000 = 40'h00_8000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, lr, sc, dbl, inv_v, clr;
  logic [PW-1:0] paddr, inv_addr;
  logic          sc_success, inv_yumi, reserved, locked;

  bp_be_dcache_lrsc_ctrl #(
    .paddr_width_p       (PW),
    .block_offset_width_p(BO),
    .lock_cycles_p       (LOCK),
    .timeout_cycles_p    (TMO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .lr_v_i      (lr),
    .sc_v_i      (sc),
    .double_i    (dbl),
    .paddr_i     (paddr),
    .sc_success_o(sc_success),
    .inv_v_i     (inv_v),
    .inv_addr_i  (inv_addr),
    .inv_yumi_o  (inv_yumi),
    .clear_i     (clr),
    .reserved_o  (reserved),
    .locked_o    (locked)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Reference: a reservation is the time of the last LR plus its block and size;
  // lock and hold windows are plain age arithmetic.
  bit               m_valid = 0;
  longint           m_lr_cyc = 0;
  logic [PW-BO-1:0] m_blk = '0;
  bit               m_dbl = 0;
  bit               m_kill;

  function automatic logic [PW-BO-1:0] blk(input logic [PW-1:0] a);
    return a[PW-1:BO];
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit l, input bit s, input bit d, input logic [PW-1:0] pa,
                       input bit iv, input logic [PW-1:0] ia, input bit c, input bit r);
    lr = l; sc = s; dbl = d; paddr = pa; inv_v = iv; inv_addr = ia; clr = c; rst_n = r;
  endtask

  task automatic idle();
    drive(0, 0, 0, A0, 0, A0, 0, 1);
  endtask

  task automatic sample();
    longint age;
    bit m_lock, m_res, inv_hit, sc_hit, m_yumi, m_sc;
    @(negedge clk);
    assert (!(lr && sc));
    age     = cyc - m_lr_cyc;
    m_lock  = m_valid && age >= 1 && age <= LOCK;
    m_res   = m_valid && age >= 1 && age <= TMO;
    inv_hit = (blk(inv_addr) == m_blk);
    sc_hit  = (blk(paddr) == m_blk) && (dbl == m_dbl);
    m_yumi  = inv_v && !(m_lock && inv_hit);
    m_kill  = m_res && inv_v && inv_hit && m_yumi;
    m_sc    = sc && m_res && sc_hit && !clr && !lr && !m_kill;
    check("model_sc_success", sc_success, m_sc);
    check("model_inv_yumi", inv_yumi, m_yumi);
    check("model_reserved", reserved, m_res);
    check("model_locked", locked, m_lock);
  endtask

  task automatic advance();
    if (!rst_n || clr) m_valid = 0;
    else if (lr) begin
      m_valid = 1; m_lr_cyc = cyc; m_blk = blk(paddr); m_dbl = dbl;
    end else if (sc || m_kill) m_valid = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic run_idle(input int n);
    idle();
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    bit lr, sc, dbl;
    logic [PW-1:0] paddr;
    bit inv_v;
    logic [PW-1:0] inv_addr;
    bit clr;
    bit e_sc, e_yumi, e_res, e_lock;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned r, lr_th, sc_th;
    bit l, s, c, rn, iv, d;
    logic [PW-1:0] pa, ia;

    //          lr sc dbl paddr  inv ia    clr  sc yumi res lock
    vecs[0]  = '{0, 0, 0, A0,    1, A40,   0,   0, 1, 0, 0};
    vecs[1]  = '{0, 1, 1, A40,   0, A0,    0,   0, 0, 0, 0};
    vecs[2]  = '{1, 0, 1, A40,   0, A0,    0,   0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, A0,    1, A40,   0,   0, 0, 1, 1};
    vecs[4]  = '{0, 1, 1, A48,   1, A40,   0,   1, 0, 1, 1};
    vecs[5]  = '{0, 0, 0, A0,    1, A40,   0,   0, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, A80,   1, A80,   0,   0, 1, 0, 0};
    vecs[7]  = '{1, 0, 1, A100,  0, A0,    0,   0, 0, 1, 1};
    vecs[8]  = '{0, 1, 1, A80,   0, A0,    0,   0, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, A0,    0, A0,    0,   0, 0, 0, 0};
    vecs[10] = '{1, 0, 1, A40,   0, A0,    1,   0, 0, 0, 0};
    vecs[11] = '{0, 1, 1, A40,   0, A0,    0,   0, 0, 0, 0};
    vecs[12] = '{1, 0, 1, A40,   0, A0,    0,   0, 0, 0, 0};
    vecs[13] = '{0, 1, 0, A40,   1, A1000, 0,   0, 1, 1, 1};
    vecs[14] = '{0, 0, 0, A0,    0, A0,    0,   0, 0, 0, 0};

    drive(0, 0, 0, A0, 0, A0, 0, 0);
    advance();
    advance();

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].lr, vecs[v].sc, vecs[v].dbl, vecs[v].paddr,
            vecs[v].inv_v, vecs[v].inv_addr, vecs[v].clr, 1);
      sample();
      check($sformatf("vec%0d_sc", v), sc_success, vecs[v].e_sc);
      check($sformatf("vec%0d_yumi", v), inv_yumi, vecs[v].e_yumi);
      check($sformatf("vec%0d_reserved", v), reserved, vecs[v].e_res);
      check($sformatf("vec%0d_locked", v), locked, vecs[v].e_lock);
      advance();
    end

    // LR.D then SC.D to another offset of the same block at +5
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    run_idle(4);
    drive(0, 1, 1, A78, 0, A0, 0, 1); sample();
    check("lrd_scd_pass", sc_success, 1'b1); advance();
    idle(); sample();
    check("lrd_scd_res_after", reserved, 1'b0); advance();

    // LR.W then SC.D: size mismatch
    drive(1, 0, 0, A40, 0, A0, 0, 1); step();
    drive(0, 1, 1, A40, 0, A0, 0, 1); sample();
    check("size_mismatch_sc", sc_success, 1'b0); advance();

    // Matching invalidate from +2 is stalled through +16, accepted at +17
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    run_idle(1);
    for (int t = 2; t <= 17; t++) begin
      drive(0, 0, 0, A0, 1, A0 + 40'h40, 0, 1); sample();
      check($sformatf("stall_yumi_t%0d", t), inv_yumi, t == 17);
      advance();
    end
    drive(0, 1, 1, A40, 0, A0, 0, 1); sample();
    check("sc_after_inv", sc_success, 1'b0); advance();

    // Non-matching invalidate is accepted at once; SC still succeeds
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    run_idle(1);
    drive(0, 0, 0, A0, 1, A1000, 0, 1); sample();
    check("nomatch_inv_yumi", inv_yumi, 1'b1); advance();
    drive(0, 1, 1, A40, 0, A0, 0, 1); sample();
    check("nomatch_inv_sc", sc_success, 1'b1); advance();

    // Timeout: held through +128, SC at +129 fails
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    idle();
    for (int t = 1; t <= TMO; t++) begin
      sample();
      check($sformatf("hold_res_t%0d", t), reserved, 1'b1);
      check($sformatf("hold_lock_t%0d", t), locked, t <= LOCK);
      advance();
    end
    drive(0, 1, 1, A40, 0, A0, 0, 1); sample();
    check("timeout_sc", sc_success, 1'b0);
    check("timeout_res", reserved, 1'b0); advance();

    // SC at +127 still succeeds
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    run_idle(TMO - 2);
    drive(0, 1, 1, A40, 0, A0, 0, 1); sample();
    check("late_sc_pass", sc_success, 1'b1); advance();

    // clear with an SC hit kills the verdict
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    run_idle(2);
    drive(0, 1, 1, A40, 0, A0, 1, 1); sample();
    check("clear_sc", sc_success, 1'b0); advance();

    // Reset mid-reservation
    drive(1, 0, 1, A40, 0, A0, 0, 1); step();
    run_idle(3);
    drive(0, 0, 0, A0, 1, A40, 0, 0); sample();
    check("rst_cycle_yumi", inv_yumi, 1'b0); advance();
    drive(0, 0, 0, A0, 1, A40, 0, 1); sample();
    check("post_rst_yumi", inv_yumi, 1'b1);
    check("post_rst_res", reserved, 1'b0);
    check("post_rst_lock", locked, 1'b0); advance();

    // Random traffic over four nearby blocks
    for (int i = 0; i < 3000; i++) begin
      lr_th = (i < 1500) ? 50 : 4;
      sc_th = (i < 1500) ? 80 : 15;
      r  = $urandom_range(0, 999);
      l  = (r < lr_th);
      s  = !l && ($urandom_range(0, 999) < sc_th);
      c  = ($urandom_range(0, 99) < 2);
      rn = ($urandom_range(0, 299) != 0);
      iv = ($urandom_range(0, 99) < 30);
      d  = $urandom_range(0, 1) != 0;
      pa = A0 + PW'($urandom_range(0, 3) * 64 + $urandom_range(0, 63));
      ia = A0 + PW'($urandom_range(0, 3) * 64);
      drive(l, s, d, pa, iv, ia, c, rn);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
